calc_entry_fsm: RTL and testbench

Keypad entry controller for the calculator datapath. Accepts one debounced key event per `key_valid` pulse from the keypad scanner and assembles two 2-digit decimal operands and an operator code. Presents them as registered digit/operator outputs with an `enable` qualifier directly to the `math` block. Sits between the keypad scanner (upstream) and `math` (downstream).

---
 rtl/calc_entry_fsm.sv | 232 +++++++++++++++++++++++
 tb/tb_calc_entry_fsm.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_entry_fsm.sv
// calc_entry_fsm: keypad entry controller for the calculator datapath.
// Collects two 2-digit decimal operands and an operator from single-cycle
// key strobes. It presents them as registered digits to the math block,
// and `enable` qualifies a complete expression.
// Optional feature macro: CALC_DIV0_GUARD_EN. When it is defined, an
// equals key that would divide by a zero B operand enters ERROR instead
// of RESULT.
module calc_entry_fsm #(
  parameter int DIGIT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key_valid,
  input  logic [5:0]         key_code,
  output logic [DIGIT_W-1:0] num000,
  output logic [DIGIT_W-1:0] num001,
  output logic [DIGIT_W-1:0] num011,
  output logic [DIGIT_W-1:0] num100,
  output logic [DIGIT_W-1:0] arithmetic,
  output logic               enable,
  output logic [1:0]         active_field,
  output logic               error
);

  typedef enum logic [1:0] {
    S_A_ENTRY = 2'd0,
    S_B_ENTRY = 2'd1,
    S_RESULT  = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  localparam logic [3:0] OP_DIV = 4'd14;

  state_t     state_reg, state_next;
  logic [3:0] a_tens_reg, a_tens_next;
  logic [3:0] a_ones_reg, a_ones_next;
  logic [3:0] b_tens_reg, b_tens_next;
  logic [3:0] b_ones_reg, b_ones_next;
  logic [3:0] arith_reg, arith_next;
  logic [1:0] a_cnt_reg, a_cnt_next;
  logic [1:0] b_cnt_reg, b_cnt_next;
  logic       enable_reg, enable_next;
  logic [1:0] field_reg, field_next;

  logic       key_digit;
  logic       key_clear;
  logic       key_op;
  logic       key_equals;
  logic [3:0] key_value;

`ifdef CALC_DIV0_GUARD_EN
  logic       error_reg, error_next;
  logic       div_by_zero;
`endif

  // Classify the incoming key; codes 16..63 fall into no class and are ignored.
  always_comb begin
    key_digit  = (key_code < 6'd10);
    key_clear  = (key_code == 6'd10);
    key_op     = (key_code >= 6'd11) && (key_code <= 6'd14);
    key_equals = (key_code == 6'd15);
    key_value  = key_code[3:0];
  end

`ifdef CALC_DIV0_GUARD_EN
  // A division whose B operand has been entered and reads as zero.
  always_comb begin
    div_by_zero = (arith_reg == OP_DIV) && (b_cnt_reg != 2'd0) &&
                  (b_tens_reg == 4'd0) && (b_ones_reg == 4'd0);
  end
`endif

  // Next-state and operand update logic; every register holds unless a key is accepted.
  always_comb begin
    state_next  = state_reg;
    a_tens_next = a_tens_reg;
    a_ones_next = a_ones_reg;
    b_tens_next = b_tens_reg;
    b_ones_next = b_ones_reg;
    arith_next  = arith_reg;
    a_cnt_next  = a_cnt_reg;
    b_cnt_next  = b_cnt_reg;

    if (key_valid) begin
      if (key_clear) begin
        // Clear works from every state and wipes the whole expression.
        state_next  = S_A_ENTRY;
        a_tens_next = 4'd0;
        a_ones_next = 4'd0;
        b_tens_next = 4'd0;
        b_ones_next = 4'd0;
        arith_next  = 4'd0;
        a_cnt_next  = 2'd0;
        b_cnt_next  = 2'd0;
      end else begin
        case (state_reg)
          S_A_ENTRY: begin
            if (key_digit) begin
              // Digits shift in from the right; a third digit is dropped.
              if (a_cnt_reg == 2'd0) begin
                a_ones_next = key_value;
                a_cnt_next  = 2'd1;
              end else if (a_cnt_reg == 2'd1) begin
                a_tens_next = a_ones_reg;
                a_ones_next = key_value;
                a_cnt_next  = 2'd2;
              end
            end else if (key_op && (a_cnt_reg != 2'd0)) begin
              arith_next = key_value;
              state_next = S_B_ENTRY;
            end
          end

          S_B_ENTRY: begin
            if (key_digit) begin
              if (b_cnt_reg == 2'd0) begin
                b_ones_next = key_value;
                b_cnt_next  = 2'd1;
              end else if (b_cnt_reg == 2'd1) begin
                b_tens_next = b_ones_reg;
                b_ones_next = key_value;
                b_cnt_next  = 2'd2;
              end
            end else if (key_op && (b_cnt_reg == 2'd0)) begin
              // The operator can still be changed until B's first digit.
              arith_next = key_value;
            end else if (key_equals && (b_cnt_reg != 2'd0)) begin
`ifdef CALC_DIV0_GUARD_EN
              state_next = div_by_zero ? S_ERROR : S_RESULT;
`else
              state_next = S_RESULT;
`endif
            end
          end

          S_RESULT, S_ERROR: begin
            // A digit starts a fresh expression with that digit as A's ones.
            if (key_digit) begin
              state_next  = S_A_ENTRY;
              a_tens_next = 4'd0;
              a_ones_next = key_value;
              b_tens_next = 4'd0;
              b_ones_next = 4'd0;
              arith_next  = 4'd0;
              a_cnt_next  = 2'd1;
              b_cnt_next  = 2'd0;
            end
          end

          default: begin
            state_next = S_A_ENTRY;
          end
        endcase
      end
    end
  end

  // Status outputs follow the next state, so they update with the operands.
  always_comb begin
    enable_next = 1'b0;
    field_next  = 2'd0;
    case (state_next)
      S_A_ENTRY: field_next = 2'd0;
      S_B_ENTRY: field_next = 2'd1;
      S_RESULT: begin
        field_next  = 2'd2;
        enable_next = 1'b1;
      end
      S_ERROR:   field_next = 2'd3;
      default:   field_next = 2'd0;
    endcase
  end

`ifdef CALC_DIV0_GUARD_EN
  // Error flag is asserted exactly while ERROR is held.
  always_comb begin
    error_next = (state_next == S_ERROR);
  end
`endif

  // State and output registers; reset wins over a simultaneous key.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_A_ENTRY;
      a_tens_reg <= 4'd0;
      a_ones_reg <= 4'd0;
      b_tens_reg <= 4'd0;
      b_ones_reg <= 4'd0;
      arith_reg  <= 4'd0;
      a_cnt_reg  <= 2'd0;
      b_cnt_reg  <= 2'd0;
      enable_reg <= 1'b0;
      field_reg  <= 2'd0;
    end else begin
      state_reg  <= state_next;
      a_tens_reg <= a_tens_next;
      a_ones_reg <= a_ones_next;
      b_tens_reg <= b_tens_next;
      b_ones_reg <= b_ones_next;
      arith_reg  <= arith_next;
      a_cnt_reg  <= a_cnt_next;
      b_cnt_reg  <= b_cnt_next;
      enable_reg <= enable_next;
      field_reg  <= field_next;
    end
  end

`ifdef CALC_DIV0_GUARD_EN
  // Error flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_reg <= 1'b0;
    end else begin
      error_reg <= error_next;
    end
  end

  assign error = error_reg;
`else
  assign error = 1'b0;
`endif

  // Digits are held as 4-bit BCD and zero-extended onto the math-facing buses.
  assign num000       = DIGIT_W'(a_tens_reg);
  assign num001       = DIGIT_W'(a_ones_reg);
  assign num011       = DIGIT_W'(b_tens_reg);
  assign num100       = DIGIT_W'(b_ones_reg);
  assign arithmetic   = DIGIT_W'(arith_reg);
  assign enable       = enable_reg;
  assign active_field = field_reg;

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Testbench for calc_entry_fsm. The driver feeds one stimulus per cycle and
// pushes the expected outputs from a value-level calculator model into a
// queue. A monitor pops the queue and compares after each rising edge.
module tb_calc_entry_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [5:0] key_code;
  logic [5:0] num000, num001, num011, num100, arithmetic;
  logic       enable;
  logic [1:0] active_field;
  logic       error;

`ifdef CALC_DIV0_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  calc_entry_fsm #(.DIGIT_W(6)) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .num000       (num000),
    .num001       (num001),
    .num011       (num011),
    .num100       (num100),
    .arithmetic   (arithmetic),
    .enable       (enable),
    .active_field (active_field),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [33:0] vec;
    bit          kv;
    bit          rs;
    int          key;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  // Model: operands kept as integer values with digit counts; mode 0 A, 1 B, 2 result, 3 error.
  int m_a, m_ac, m_b, m_bc, m_op, m_mode;

  function automatic logic [33:0] mkv(int n0, int n1, int n2, int n3, int ar,
                                      int en, int af, int er);
    logic [33:0] v;
    v = {6'(n0), 6'(n1), 6'(n2), 6'(n3), 6'(ar), 1'(en), 2'(af), 1'(er)};
    return v;
  endfunction

  function automatic logic [33:0] model_vec();
    return mkv(m_a / 10, m_a % 10, m_b / 10, m_b % 10, m_op,
               (m_mode == 2) ? 1 : 0, m_mode, (m_mode == 3) ? 1 : 0);
  endfunction

  task automatic model_clear();
    m_a = 0; m_ac = 0; m_b = 0; m_bc = 0; m_op = 0; m_mode = 0;
  endtask

  task automatic model_key(input int k);
    if (k == 10) begin
      model_clear();
    end else if (k < 10) begin
      if (m_mode == 0) begin
        if (m_ac < 2) begin m_a = m_a * 10 + k; m_ac++; end
      end else if (m_mode == 1) begin
        if (m_bc < 2) begin m_b = m_b * 10 + k; m_bc++; end
      end else begin
        model_clear();
        m_a = k; m_ac = 1;
      end
    end else if (k >= 11 && k <= 14) begin
      if (m_mode == 0 && m_ac > 0) begin m_op = k; m_mode = 1; end
      else if (m_mode == 1 && m_bc == 0) m_op = k;
    end else if (k == 15) begin
      if (m_mode == 1 && m_bc > 0)
        m_mode = (GUARD && m_op == 14 && m_b == 0) ? 3 : 2;
    end
  endtask

  function automatic logic [33:0] dut_vec();
    return {num000, num001, num011, num100, arithmetic, enable, active_field, error};
  endfunction

  // Apply one cycle of stimulus, record its expected outcome, wait to the next falling edge.
  task automatic step(input bit r, input bit v, input int k);
    exp_t e;
    reset     = r;
    key_valid = v;
    key_code  = 6'(k);
    if (r) model_clear();
    else if (v) model_key(k);
    e.vec = model_vec();
    e.kv  = v;
    e.rs  = r;
    e.key = k;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic keys(input int ks[]);
    foreach (ks[i]) step(1'b0, 1'b1, ks[i]);
    step(1'b0, 1'b0, 0);
  endtask

  // Directed checkpoint against hand-derived constants.
  task automatic check_plan(input string name, input logic [33:0] want);
    checks++;
    if (dut_vec() !== want) begin
      failures++;
      $display("FAIL %s: got=%h want=%h", name, dut_vec(), want);
    end
  endtask

  // Monitor: after every rising edge compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        if (!done) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow: got=empty want=entry");
        end
      end else begin
        e = q.pop_front();
        checks++;
        if (dut_vec() !== e.vec) begin
          failures++;
          $display("FAIL cycle_out: rst=%0d kv=%0d key=%0d got=%h want=%h",
                   e.rs, e.kv, e.key, dut_vec(), e.vec);
        end else if (e.kv || e.rs) begin
          $display("txn rst=%0d key=%0d out=%h", e.rs, e.key, e.vec);
        end
      end
    end
  end

  initial begin
    int r;
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    check_plan("reset_state", mkv(0, 0, 0, 0, 0, 0, 0, 0));

    keys('{4, 2, 11, 1, 7, 15});
    check_plan("plan_add", mkv(4, 2, 1, 7, 11, 1, 2, 0));
    keys('{5, 12, 3, 15});
    check_plan("plan_sub", mkv(0, 5, 0, 3, 12, 1, 2, 0));
    keys('{1, 2, 3});
    check_plan("plan_third_digit", mkv(1, 2, 0, 0, 0, 0, 0, 0));
    keys('{11, 13, 2, 15});
    check_plan("plan_op_replace", mkv(1, 2, 0, 2, 13, 1, 2, 0));
    keys('{7, 13, 15});
    check_plan("plan_eq_no_b", mkv(0, 7, 0, 0, 13, 0, 1, 0));
    keys('{10, 8, 14, 0, 15});
    if (GUARD) check_plan("plan_div0", mkv(0, 8, 0, 0, 14, 0, 3, 1));
    else       check_plan("plan_div0", mkv(0, 8, 0, 0, 14, 1, 2, 0));
    keys('{6});
    check_plan("plan_exit", mkv(0, 6, 0, 0, 0, 0, 0, 0));
    keys('{4, 11, 9, 10});
    check_plan("plan_clear", mkv(0, 0, 0, 0, 0, 0, 0, 0));
    keys('{5, 11, 20, 63});
    step(1'b1, 1'b1, 3);
    check_plan("plan_reset_drop", mkv(0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < 800; i++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 79) == 0) begin
        step(1'b1, $urandom_range(0, 1) == 1, r % 16);
      end else if ($urandom_range(0, 9) < 6) begin
        if (r < 45)      step(1'b0, 1'b1, r % 10);
        else if (r < 49) step(1'b0, 1'b1, 10);
        else if (r < 70) step(1'b0, 1'b1, 11 + (r % 4));
        else if (r < 85) step(1'b0, 1'b1, 15);
        else             step(1'b0, 1'b1, int'($urandom_range(16, 63)));
      end else begin
        step(1'b0, 1'b0, int'($urandom_range(0, 63)));
      end
    end
    step(1'b0, 1'b0, 0);
    done = 1'b1;
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
